timer_core_mc: RTL and testbench

- Parametrised successor to the single free-running cycle timer: a wide counter with programmable prescaler, NUM_CMP compare channels (one-shot or periodic) and a level interrupt.
- Register-mapped IO-bus slave behind the IO interconnect; the CPU uses it for delays, scheduling and periodic tick interrupts.

---
 rtl/timer_core_mc_pkg.sv | 35 +++
 rtl/timer_cmp_channel.sv | 62 ++++++
 rtl/timer_core_mc.sv | 186 ++++++++++++++++++
 tb/tb_timer_core_mc.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_core_mc_pkg.sv
// Register map, control-bit positions and shared types for timer_core_mc.
package timer_core_mc_pkg;

  localparam logic [7:0] TIMER_CTRL_OFS       = 8'h00;
  localparam logic [7:0] TIMER_PRESCALE_OFS   = 8'h04;
  localparam logic [7:0] TIMER_COUNT_LO_OFS   = 8'h08;
  localparam logic [7:0] TIMER_COUNT_HI_OFS   = 8'h0C;
  localparam logic [7:0] TIMER_STATUS_OFS     = 8'h10;
  localparam logic [7:0] TIMER_IRQ_EN_OFS     = 8'h14;
  localparam logic [7:0] TIMER_CAPTURE_LO_OFS = 8'h18;
  localparam logic [7:0] TIMER_CAPTURE_HI_OFS = 8'h1C;
  localparam logic [7:0] TIMER_CMP_BASE       = 8'h20;
  localparam logic [7:0] TIMER_CMP_STRIDE     = 8'h10;

  // Word slots inside one compare channel
  localparam logic [1:0] CMP_LO_SEL     = 2'd0;
  localparam logic [1:0] CMP_HI_SEL     = 2'd1;
  localparam logic [1:0] CMP_PERIOD_SEL = 2'd2;
  localparam logic [1:0] CMP_CTRL_SEL   = 2'd3;

  localparam int CTRL_EN_BIT           = 0;
  localparam int CTRL_CLR_BIT          = 1;
  localparam int CMP_CTRL_ENA_BIT      = 0;
  localparam int CMP_CTRL_PERIODIC_BIT = 1;

  typedef struct packed {
    logic periodic;
    logic ena;
  } cmp_ctrl_t;

  function automatic logic [5:0] word_idx(input logic [7:0] ofs);
    return ofs[7:2];
  endfunction

endpackage

// File: rtl/timer_cmp_channel.sv
// One compare channel: CMP/PERIOD/CTRL registers, match detect and periodic reload.
module timer_cmp_channel
  import timer_core_mc_pkg::*;
#(
  parameter int COUNTER_WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [COUNTER_WIDTH-1:0] counter_next,
  input  logic                     tick,
  input  logic                     wr_en,
  input  logic [1:0]               reg_sel,
  input  logic [31:0]              wr_data,
  output logic                     match,
  output logic [31:0]              rd_data
);

  logic [COUNTER_WIDTH-1:0] cmp_q;
  logic [31:0]              period_q;
  cmp_ctrl_t                ctrl_q;
  logic [63:0]              cmp_wide;
  logic [63:0]              cmp_wr;

  assign cmp_wide = 64'(cmp_q);
  assign match    = tick & ctrl_q.ena & (counter_next == cmp_q);

  always_comb begin
    cmp_wr = cmp_wide;
    if (reg_sel == CMP_HI_SEL) cmp_wr[63:32] = wr_data;
    else                       cmp_wr[31:0]  = wr_data;
  end

  // A CPU write to CMP outranks the periodic reload in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_q    <= '0;
      period_q <= '0;
      ctrl_q   <= '0;
    end else begin
      if (wr_en && (reg_sel == CMP_LO_SEL || reg_sel == CMP_HI_SEL))
        cmp_q <= cmp_wr[COUNTER_WIDTH-1:0];
      else if (match && ctrl_q.periodic)
        cmp_q <= cmp_q + COUNTER_WIDTH'(period_q);
      if (wr_en && reg_sel == CMP_PERIOD_SEL) period_q <= wr_data;
      if (wr_en && reg_sel == CMP_CTRL_SEL) begin
        ctrl_q.ena      <= wr_data[CMP_CTRL_ENA_BIT];
        ctrl_q.periodic <= wr_data[CMP_CTRL_PERIODIC_BIT];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      CMP_LO_SEL:     rd_data = cmp_wide[31:0];
      CMP_HI_SEL:     rd_data = cmp_wide[63:32];
      CMP_PERIOD_SEL: rd_data = period_q;
      default:        rd_data = {30'b0, ctrl_q};
    endcase
  end

endmodule

// File: rtl/timer_core_mc.sv
// Multi-channel timer: prescaled wide counter, NUM_CMP compare channels, level IRQ.
// Defining TIMER_CAPTURE_EN adds the capture_trig input and CAPTURE_LO/HI registers.
module timer_core_mc
  import timer_core_mc_pkg::*;
#(
  parameter int COUNTER_WIDTH  = 64,
  parameter int NUM_CMP        = 2,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_bus_s_rd_en,
  input  logic        io_bus_s_wr_en,
  input  logic        io_bus_s_cs,
  input  logic [31:0] io_bus_s_address,
  input  logic [31:0] io_bus_s_wr_data,
`ifdef TIMER_CAPTURE_EN
  input  logic        capture_trig,
`endif
  output logic [31:0] rd_data,
  output logic        timer_irq
);

`ifdef TIMER_CAPTURE_EN
  localparam int STAT_W = NUM_CMP + 1;
`else
  localparam int STAT_W = NUM_CMP;
`endif

  localparam logic [5:0] W_CTRL     = word_idx(TIMER_CTRL_OFS);
  localparam logic [5:0] W_PRESCALE = word_idx(TIMER_PRESCALE_OFS);
  localparam logic [5:0] W_COUNT_LO = word_idx(TIMER_COUNT_LO_OFS);
  localparam logic [5:0] W_COUNT_HI = word_idx(TIMER_COUNT_HI_OFS);
  localparam logic [5:0] W_STATUS   = word_idx(TIMER_STATUS_OFS);
  localparam logic [5:0] W_IRQ_EN   = word_idx(TIMER_IRQ_EN_OFS);
  localparam logic [5:0] W_CMP_BASE = word_idx(TIMER_CMP_BASE);

  logic                      rd_acc, wr_acc;
  logic [5:0]                word;
  logic [5:0]                ch_off;
  logic [3:0]                ch_idx;
  logic                      in_cmp;
  logic                      unused_addr_bits;

  logic                      en_q;
  logic [PRESCALE_WIDTH-1:0] prescale_q, psc_cnt_q;
  logic [COUNTER_WIDTH-1:0]  count_q, count_next, count_inc;
  logic [63:0]               count_wide, count_wr;
  logic [31:0]               shadow_q;
  logic [STAT_W-1:0]         status_q, status_next, irq_en_q, irq_en_next, stat_set;
  logic                      clr, tick, tick_eff;
  logic                      wr_count;

  logic [NUM_CMP-1:0]        match;
  logic [31:0]               ch_rd [NUM_CMP];
  logic [31:0]               ch_rd_sel;

  assign rd_acc           = io_bus_s_cs & io_bus_s_rd_en;
  assign wr_acc           = io_bus_s_cs & io_bus_s_wr_en;
  assign word             = io_bus_s_address[7:2];
  assign unused_addr_bits = ^{io_bus_s_address[31:8], io_bus_s_address[1:0]};
  assign ch_off           = word - W_CMP_BASE;
  assign ch_idx           = ch_off[5:2];
  assign in_cmp           = (word >= W_CMP_BASE) && (int'(ch_idx) < NUM_CMP);

  // CLR cancels any tick in the same cycle, so matches see the cleared counter
  assign clr       = wr_acc && (word == W_CTRL) && io_bus_s_wr_data[CTRL_CLR_BIT];
  assign tick      = en_q && (psc_cnt_q == prescale_q);
  assign tick_eff  = tick && !clr;
  assign count_inc = count_q + COUNTER_WIDTH'(1);
  assign count_wide = 64'(count_q);
  assign wr_count  = wr_acc && !en_q && (word == W_COUNT_LO || word == W_COUNT_HI);

  always_comb begin
    count_wr = count_wide;
    if (word == W_COUNT_HI) count_wr[63:32] = io_bus_s_wr_data;
    else                    count_wr[31:0]  = io_bus_s_wr_data;
  end

  always_comb begin
    count_next = count_q;
    if (clr)           count_next = '0;
    else if (tick_eff) count_next = count_inc;
    else if (wr_count) count_next = count_wr[COUNTER_WIDTH-1:0];
  end

  for (genvar n = 0; n < NUM_CMP; n++) begin : g_ch
    timer_cmp_channel #(
      .COUNTER_WIDTH(COUNTER_WIDTH)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .counter_next(count_inc),
      .tick        (tick_eff),
      .wr_en       (wr_acc && in_cmp && (ch_idx == 4'(n))),
      .reg_sel     (ch_off[1:0]),
      .wr_data     (io_bus_s_wr_data),
      .match       (match[n]),
      .rd_data     (ch_rd[n])
    );
  end

`ifdef TIMER_CAPTURE_EN
  logic                     cap_p0, cap_p1, cap_p2;
  logic                     cap_edge;
  logic [COUNTER_WIDTH-1:0] capture_q;
  logic [63:0]              cap_wide;

  assign cap_edge = cap_p1 & ~cap_p2;
  assign cap_wide = 64'(capture_q);
  assign stat_set = {cap_edge, match};

  // Two-flop synchronizer, then a third flop for rising-edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_p0    <= 1'b0;
      cap_p1    <= 1'b0;
      cap_p2    <= 1'b0;
      capture_q <= '0;
    end else begin
      cap_p0 <= capture_trig;
      cap_p1 <= cap_p0;
      cap_p2 <= cap_p1;
      if (cap_edge) capture_q <= count_q;
    end
  end
`else
  assign stat_set = match;
`endif

  // A new match wins over a W1C of the same bit
  always_comb begin
    status_next = status_q;
    irq_en_next = irq_en_q;
    if (wr_acc && word == W_STATUS) status_next = status_q & ~io_bus_s_wr_data[STAT_W-1:0];
    status_next = status_next | stat_set;
    if (wr_acc && word == W_IRQ_EN) irq_en_next = io_bus_s_wr_data[STAT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q       <= 1'b0;
      prescale_q <= '0;
      psc_cnt_q  <= '0;
      count_q    <= '0;
      shadow_q   <= '0;
      status_q   <= '0;
      irq_en_q   <= '0;
      timer_irq  <= 1'b0;
    end else begin
      if (wr_acc && word == W_CTRL)     en_q       <= io_bus_s_wr_data[CTRL_EN_BIT];
      if (wr_acc && word == W_PRESCALE) prescale_q <= io_bus_s_wr_data[PRESCALE_WIDTH-1:0];
      if (clr || tick)  psc_cnt_q <= '0;
      else if (en_q)    psc_cnt_q <= psc_cnt_q + PRESCALE_WIDTH'(1);
      if (rd_acc && word == W_COUNT_LO) shadow_q <= count_wide[63:32];
      count_q   <= count_next;
      status_q  <= status_next;
      irq_en_q  <= irq_en_next;
      timer_irq <= |(status_next & irq_en_next);
    end
  end

  always_comb begin
    ch_rd_sel = '0;
    for (int n = 0; n < NUM_CMP; n++)
      if (ch_idx == 4'(n)) ch_rd_sel = ch_rd[n];
  end

  always_comb begin
    rd_data = '0;
    case (word)
      W_CTRL:     rd_data[CTRL_EN_BIT] = en_q;
      W_PRESCALE: rd_data = 32'(prescale_q);
      W_COUNT_LO: rd_data = count_wide[31:0];
      W_COUNT_HI: rd_data = shadow_q;
      W_STATUS:   rd_data = 32'(status_q);
      W_IRQ_EN:   rd_data = 32'(irq_en_q);
`ifdef TIMER_CAPTURE_EN
      word_idx(TIMER_CAPTURE_LO_OFS): rd_data = cap_wide[31:0];
      word_idx(TIMER_CAPTURE_HI_OFS): rd_data = cap_wide[63:32];
`endif
      default:    if (in_cmp) rd_data = ch_rd_sel;
    endcase
  end

endmodule

// File: tb/tb_timer_core_mc.sv
// Self-checking bench for timer_core_mc: directed scenarios plus random bus traffic vs a reference model.
module tb_timer_core_mc;

  localparam int CW = 64;
  localparam int NC = 2;
  localparam int PW = 16;
`ifdef TIMER_CAPTURE_EN
  localparam int SW = NC + 1;
`else
  localparam int SW = NC;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en, cs;
  logic [31:0] addr, wdata, rd_data;
  logic        timer_irq;
`ifdef TIMER_CAPTURE_EN
  logic        capture_trig = 1'b0;
`endif

  always #5 clk = ~clk;

  timer_core_mc #(
    .COUNTER_WIDTH (CW),
    .NUM_CMP       (NC),
    .PRESCALE_WIDTH(PW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .io_bus_s_rd_en  (rd_en),
    .io_bus_s_wr_en  (wr_en),
    .io_bus_s_cs     (cs),
    .io_bus_s_address(addr),
    .io_bus_s_wr_data(wdata),
`ifdef TIMER_CAPTURE_EN
    .capture_trig    (capture_trig),
`endif
    .rd_data         (rd_data),
    .timer_irq       (timer_irq)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [63:0]   m_count;
  logic [PW-1:0] m_psc, m_prescale;
  logic          m_en;
  logic [31:0]   m_shadow;
  logic [SW-1:0] m_status, m_irq_en;
  logic [63:0]   m_cmp [NC];
  logic [31:0]   m_period [NC];
  logic          m_ena [NC];
  logic          m_per [NC];
`ifdef TIMER_CAPTURE_EN
  logic [63:0]   m_cap;
  logic          m_h1, m_h2, m_h3;
`endif

  task automatic m_reset();
    m_count = 0; m_psc = 0; m_prescale = 0; m_en = 0; m_shadow = 0;
    m_status = 0; m_irq_en = 0;
    for (int n = 0; n < NC; n++) begin
      m_cmp[n] = 0; m_period[n] = 0; m_ena[n] = 0; m_per[n] = 0;
    end
`ifdef TIMER_CAPTURE_EN
    m_cap = 0; m_h1 = 0; m_h2 = 0; m_h3 = 0;
`endif
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int w;
    logic [31:0] r;
    w = int'(a[7:2]);
    r = 0;
    if (w == 0)      r = {31'b0, m_en};
    else if (w == 1) r = 32'(m_prescale);
    else if (w == 2) r = m_count[31:0];
    else if (w == 3) r = m_shadow;
    else if (w == 4) r = 32'(m_status);
    else if (w == 5) r = 32'(m_irq_en);
`ifdef TIMER_CAPTURE_EN
    else if (w == 6) r = m_cap[31:0];
    else if (w == 7) r = m_cap[63:32];
`endif
    else if (w >= 8 && (w - 8) / 4 < NC) begin
      case ((w - 8) % 4)
        0:       r = m_cmp[(w - 8) / 4][31:0];
        1:       r = m_cmp[(w - 8) / 4][63:32];
        2:       r = m_period[(w - 8) / 4];
        default: r = {30'b0, m_per[(w - 8) / 4], m_ena[(w - 8) / 4]};
      endcase
    end
    return r;
  endfunction

  // One clock edge of the specified behaviour
  task automatic m_step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    int wi;
    logic clr, tick, te;
    logic [63:0] old, inc;
    logic [SW-1:0] set;
    wi   = int'(a[7:2]);
    set  = '0;
    clr  = w && wi == 0 && d[1];
    tick = m_en && (m_psc == m_prescale);
    te   = tick && !clr;
    old  = m_count;
    inc  = old + 64'd1;
    for (int n = 0; n < NC; n++)
      if (te && m_ena[n] && inc == m_cmp[n]) set[n] = 1'b1;
`ifdef TIMER_CAPTURE_EN
    if (m_h2 && !m_h3) begin set[NC] = 1'b1; m_cap = old; end
    m_h3 = m_h2; m_h2 = m_h1; m_h1 = capture_trig;
`endif
    if (clr || tick) m_psc = 0;
    else if (m_en)   m_psc = m_psc + 1'b1;
    if (r && wi == 2) m_shadow = old[63:32];
    if (clr)                         m_count = 0;
    else if (te)                     m_count = inc;
    else if (w && !m_en && wi == 2)  m_count[31:0] = d;
    else if (w && !m_en && wi == 3)  m_count[63:32] = d;
    for (int n = 0; n < NC; n++) begin
      int b = 8 + 4 * n;
      if (w && wi == b)               m_cmp[n][31:0] = d;
      else if (w && wi == b + 1)      m_cmp[n][63:32] = d;
      else if (set[n] && m_per[n])    m_cmp[n] = m_cmp[n] + 64'(m_period[n]);
      if (w && wi == b + 2) m_period[n] = d;
      if (w && wi == b + 3) begin m_ena[n] = d[0]; m_per[n] = d[1]; end
    end
    if (w && wi == 4) m_status = m_status & ~d[SW-1:0];
    m_status = m_status | set;
    if (w && wi == 0) m_en = d[0];
    if (w && wi == 1) m_prescale = d[PW-1:0];
    if (w && wi == 5) m_irq_en = d[SW-1:0];
  endtask

  // One bus cycle, entered and left at a falling edge
  task automatic cyc(input logic c, input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] q);
    cs = c; rd_en = r; wr_en = w; addr = a; wdata = d;
    #1;
    q = rd_data;
    if (c && r) check($sformatf("rd@%02h", a[7:0]), rd_data, m_read(a));
    @(posedge clk);
    m_step(c && r, c && w, a, d);
    @(negedge clk);
    check("irq", timer_irq, |(m_status & m_irq_en));
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] q;
    cyc(1'b1, 1'b0, 1'b1, a, d, q);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] q);
    cyc(1'b1, 1'b1, 1'b0, a, 32'd0, q);
  endtask

  task automatic idle(input int n);
    logic [31:0] q;
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, q);
  endtask

  task automatic do_reset();
    rst = 1'b1; cs = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    @(posedge clk);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    check("rst_irq", timer_irq, 1'b0);
  endtask

  task automatic wait_irq(input string tag, input int bound);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      idle(1);
      seen = timer_irq;
    end
    check(tag, seen, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    logic [31:0] q;
    for (int i = 0; i < 16; i++) begin
      rd(32'(i * 4), q);
      check($sformatf("%s_%02h", tag, i * 4), q, 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] q, n0;
    rst = 1'b1; cs = 1'b0; rd_en = 1'b0; wr_en = 1'b0; addr = 0; wdata = 0;
    m_reset();
    @(negedge clk);
    do_reset();
    check_all_zero("reset");

    // Free run at full rate
    wr(32'h04, 0);
    wr(32'h00, 1);
    idle(10);
    rd(32'h08, q); check("run10_lo", q, 32'd10);
    rd(32'h0C, q); check("run10_hi", q, 32'd0);
    check("run10_irq", timer_irq, 1'b0);

    // Prescaler 3, then hold with EN=0
    do_reset();
    wr(32'h04, 3);
    wr(32'h00, 1);
    idle(40);
    rd(32'h08, q); check("psc_lo", q, 32'd10);
    wr(32'h00, 0);
    idle(20);
    rd(32'h08, q); check("hold_lo", q, 32'd10);

    // Counter writes, carry into HI, shadow, writes ignored while enabled
    do_reset();
    wr(32'h08, 32'hFFFF_FFFE);
    wr(32'h0C, 0);
    wr(32'h00, 1);
    idle(3);
    rd(32'h08, q); check("carry_lo", q, 32'd1);
    rd(32'h0C, q); check("carry_hi", q, 32'd1);
    wr(32'h08, 32'h1234);
    rd(32'h08, q); check("wr_ignored_lo", q, 32'd4);

    // Periodic channel 0
    do_reset();
    wr(32'h20, 100); wr(32'h24, 0); wr(32'h28, 50); wr(32'h2C, 3);
    wr(32'h14, 1);
    wr(32'h00, 1);
    wait_irq("per_irq100", 200);
    rd(32'h08, q); check("per_cnt100", q, 32'd100);
    wr(32'h10, 1);
    rd(32'h10, q); check("per_w1c", q, 32'd0);
    wait_irq("per_irq150", 200);
    rd(32'h08, q); check("per_cnt150", q, 32'd150);
    wr(32'h10, 1);
    idle(47);
    wr(32'h10, 1);
    rd(32'h10, q); check("per_set_vs_w1c", q, 32'd1);
    rd(32'h20, q); check("per_reload", q, 32'd250);

    // One-shot channel 1, CLR, rematch after clear, reset mid-run
    do_reset();
    wr(32'h30, 5); wr(32'h3C, 1); wr(32'h14, 2);
    wr(32'h00, 1);
    idle(10);
    rd(32'h10, q); check("os_status", q, 32'd2);
    rd(32'h30, q); check("os_cmp_kept", q, 32'd5);
    wr(32'h10, 2);
    idle(10);
    rd(32'h10, q); check("os_no_rematch", q, 32'd0);
    wr(32'h00, 3);
    rd(32'h08, q); check("clr_lo", q, 32'd0);
    idle(8);
    rd(32'h10, q); check("os_rematch", q, 32'd2);
    check("os_irq", timer_irq, 1'b1);
    do_reset();
    check_all_zero("midrst");

`ifdef TIMER_CAPTURE_EN
    do_reset();
    wr(32'h00, 1);
    idle(5);
    capture_trig = 1'b1;
    rd(32'h08, n0);
    idle(1);
    capture_trig = 1'b0;
    idle(4);
    rd(32'h18, q); check("cap_lo", q, n0 + 32'd2);
    rd(32'h10, q); check("cap_status", q[NC], 1'b1);
`endif

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      int wi, kind;
      logic c, r, w;
      logic [31:0] a, d;
      if ($urandom_range(0, 799) == 0) begin
        do_reset();
        continue;
      end
`ifdef TIMER_CAPTURE_EN
      if ($urandom_range(0, 15) == 0) capture_trig = ~capture_trig;
`endif
      wi   = (($urandom_range(0, 9) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 23));
      d    = $urandom;
      case (wi)
        0:       d = {30'b0, ($urandom_range(0, 15) == 0), ($urandom_range(0, 4) != 0)};
        1:       d = $urandom_range(0, 3);
        8, 12:   d = m_count[31:0] + $urandom_range(0, 30);
        9, 13:   d = m_count[63:32];
        10, 14:  d = $urandom_range(1, 20);
        11, 15:  d = ($urandom_range(0, 3) == 0) ? 32'd0 : {30'b0, 1'b1 & 1'($urandom), 1'b1};
        default: ;
      endcase
      a    = {24'd0, 6'(wi), 2'($urandom)};
      kind = $urandom_range(0, 99);
      c    = ($urandom_range(0, 9) != 0);
      r    = (kind >= 60 && kind < 80);
      w    = (kind >= 80);
      cyc(c, r, w, a, d, q);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
